// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side master for the synchronous FIFO. A start command loads a burst
// length; the block then pulls that many words out of the FIFO (absorbing the
// FIFO's one-cycle registered read latency) and presents them on a
// valid/ready stream with a last-word flag. A 2-entry output buffer keeps one
// word per cycle flowing under continuous m_ready and prevents over-reading
// the FIFO while the consumer stalls.
//
// Ports:
//   clk         - single clock, rising edge
//   rst         - asynchronous active-low reset
//   start       - burst request, sampled only while busy = 0
//   burst_len   - number of words to read, sampled with start
//   busy        - high from accepted start until the last word is handshaken
//   done        - one-cycle pulse after the final handshake / zero-length start
//   fifo_empty  - FIFO empty flag
//   fifo_data   - FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en  - FIFO read enable (combinational)
//   m_valid     - stream word valid
//   m_ready     - stream consumer ready
//   m_data      - stream word (buffer head)
//   m_last      - final word of the burst
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    output logic                  busy,
    output logic                  done,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [LEN_WIDTH-1:0]  LEN_ZERO  = {LEN_WIDTH{1'b0}};
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_ZERO + 1'b1;
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

    state_t                  state_q,     state_d;
    logic [LEN_WIDTH-1:0]    issue_rem_q, issue_rem_d;
    logic [LEN_WIDTH-1:0]    out_rem_q,   out_rem_d;
    logic [1:0]              occ_q,       occ_d;
    logic                    inflight_q,  inflight_d;
    logic [DATA_WIDTH-1:0]   buf0_q,      buf0_d;     // head entry
    logic [DATA_WIDTH-1:0]   buf1_q,      buf1_d;     // second entry
    logic                    busy_q,      busy_d;
    logic                    done_q,      done_d;

    logic                    pop_s;
    logic                    rd_en_s;

    // Handshake and read-issue decision.
    // A read may be issued only if the word it returns will have a slot when
    // it lands: buffered + in-flight + this read must not exceed 2, counting
    // the slot freed by a pop in this same cycle.
    always_comb begin
        pop_s   = (occ_q != 2'd0) & m_ready;
        rd_en_s = (state_q == ST_RUN) &&
                  (issue_rem_q != LEN_ZERO) &&
                  !fifo_empty &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop_s}));
    end

    // Next-state logic for control, counters and the 2-entry buffer.
    always_comb begin
        state_d     = state_q;
        issue_rem_d = issue_rem_q;
        out_rem_d   = out_rem_q;
        occ_d       = occ_q;
        inflight_d  = rd_en_s;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len != LEN_ZERO) begin
                        issue_rem_d = burst_len;
                        out_rem_d   = burst_len;
                        state_d     = ST_RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (rd_en_s) begin
                    issue_rem_d = issue_rem_q - LEN_ONE;
                end else begin
                    issue_rem_d = issue_rem_q;
                end
                if (pop_s && (out_rem_q != LEN_ZERO)) begin
                    out_rem_d = out_rem_q - LEN_ONE;
                end else begin
                    out_rem_d = out_rem_q;
                end
                if (pop_s && (out_rem_q == LEN_ONE)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Buffer: capture lands at the tail, pop shifts entry 1 to the head.
        case ({inflight_q, pop_s})
            2'b01: begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) begin
                    buf0_d = fifo_data;
                end else begin
                    buf1_d = fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b11: begin
                // Capture and pop together: occupancy unchanged.
                if (occ_q == 2'd2) begin
                    buf0_d = buf1_q;
                    buf1_d = fifo_data;
                end else begin
                    buf0_d = fifo_data;
                end
            end
            default: begin
                occ_d = occ_q;
            end
        endcase

        busy_d = (state_d == ST_RUN);
    end

    // State register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            issue_rem_q <= LEN_ZERO;
            out_rem_q   <= LEN_ZERO;
            occ_q       <= 2'd0;
            inflight_q  <= 1'b0;
            buf0_q      <= DATA_ZERO;
            buf1_q      <= DATA_ZERO;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            issue_rem_q <= issue_rem_d;
            out_rem_q   <= out_rem_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign fifo_rd_en = rd_en_s;
    assign m_valid    = (occ_q != 2'd0);
    assign m_data     = buf0_q;
    assign m_last     = (occ_q != 2'd0) && (out_rem_q == LEN_ONE);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// Testbench for fifo_burst_reader. A behavioural FIFO (queue with registered
// read data) feeds the DUT; a negedge monitor records stream handshakes and
// protocol violations; each test task compares the recorded stream against
// the words it loaded into the FIFO.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 8;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [LW-1:0] burst_len = '0;
    logic          busy;
    logic          done;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;

    int errors = 0;
    int checks = 0;

    fifo_burst_reader #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .burst_len(burst_len),
        .busy(busy), .done(done), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
    );

    always #5 clk = ~clk;

    // Cycle counter (counts rising edges).
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural FIFO: registered read data, empty flag updated at the edge.
    logic [DW-1:0] fq[$];
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          flush_req = 1'b0;
    always @(posedge clk) begin
        if (flush_req) begin
            fq.delete();
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_data <= fq.pop_front();
            if (wr_req) fq.push_back(wr_data);
        end
        fifo_empty <= (fq.size() == 0);
    end

    // Consumer ready: 0 always ready, 1 random, 3 held low.
    int ready_mode = 0;
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0: m_ready = 1'b1;
            1: m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: handshakes and protocol violations.
    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            got_cyc[$];
    int rd_total = 0, done_total = 0, done_cyc = 0, outs = 0;
    int viol_empty = 0, viol_outs = 0, viol_stable = 0, viol_busy = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_data = '0;
    always @(negedge clk) begin
        if (!rst) begin
            outs = 0;
            prev_stall = 0;
        end else begin
            if (fifo_rd_en) rd_total++;
            if (fifo_rd_en && fifo_empty) viol_empty++;
            if (prev_stall && (!m_valid || m_data !== prev_data)) viol_stable++;
            if (m_valid && m_ready) begin
                got_data.push_back(m_data);
                got_last.push_back(m_last);
                got_cyc.push_back(cyc);
            end
            outs = outs + (fifo_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
            if (outs > 2) viol_outs++;
            if (done) begin
                done_total++;
                done_cyc = cyc;
                if (busy) viol_busy++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
        end
    end

    // ---------------- stimulus helpers (no comparisons) ----------------
    task automatic push_word(input logic [DW-1:0] w);
        @(posedge clk); #1;
        wr_req = 1'b1; wr_data = w;
        @(posedge clk); #1;
        wr_req = 1'b0;
    endtask

    task automatic flush_fifo();
        @(posedge clk); #1;
        flush_req = 1'b1;
        @(posedge clk); #1;
        flush_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_start(input int len, output int c0);
        @(posedge clk); #1;
        start = 1'b1; burst_len = LW'(len);
        @(posedge clk); #1;
        c0 = cyc;
        start = 1'b0;
    endtask

    task automatic wait_done(input int base, input int limit, output bit ok);
        ok = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done_total > base) begin ok = 1; break; end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({busy, done, m_valid, m_last, fifo_rd_en} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got=%b exp=00000", {busy, done, m_valid, m_last, fifo_rd_en});
        end
        checks++; if (m_data !== 8'h00) begin
            errors++; $display("FAIL reset_data got=%h exp=00", m_data);
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0 || m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset busy=%b valid=%b rd=%b exp 0", busy, m_valid, fifo_rd_en);
        end
    endtask

    task automatic test_basic();
        int gb, rb, db, c0, lat, n;
        bit ok;
        logic [DW-1:0] e;
        flush_fifo();
        for (int i = 0; i < 5; i++) push_word(8'(8'h10 + i));
        ready_mode = 0;
        gb = got_data.size(); rb = rd_total; db = done_total;
        do_start(5, c0);
        lat = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_valid) begin lat = cyc - c0; break; end
        end
        checks++; if (lat != 2) begin
            errors++; $display("FAIL basic_latency got=%0d exp=2", lat);
        end
        wait_done(db, 50, ok);
        checks++; if (!ok) begin
            errors++; $display("FAIL basic_done_timeout got=0 exp=1");
        end
        n = got_data.size() - gb;
        checks++; if (n != 5) begin
            errors++; $display("FAIL basic_count got=%0d exp=5", n);
        end
        if (n == 5) begin
            for (int i = 0; i < 5; i++) begin
                e = 8'(8'h10 + i);
                checks++; if (got_data[gb+i] !== e || got_last[gb+i] !== (i == 4)) begin
                    errors++; $display("FAIL basic_word%0d got=%h/%b exp=%h/%b", i, got_data[gb+i], got_last[gb+i], e, i == 4);
                end
            end
            checks++; if (got_cyc[gb+4] - got_cyc[gb] != 4) begin
                errors++; $display("FAIL basic_no_bubbles span=%0d exp=4", got_cyc[gb+4] - got_cyc[gb]);
            end
            checks++; if (done_cyc != got_cyc[gb+4] + 1) begin
                errors++; $display("FAIL basic_done_timing got=%0d exp=%0d", done_cyc, got_cyc[gb+4] + 1);
            end
        end
        checks++; if (rd_total - rb != 5) begin
            errors++; $display("FAIL basic_reads got=%0d exp=5", rd_total - rb);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_done_pulse done=%b busy=%b exp 0/0", done, busy);
        end
    endtask

    task automatic test_partial();
        logic [DW-1:0] w[8];
        int gb, rb, db, c0, n;
        bit ok;
        flush_fifo();
        for (int i = 0; i < 8; i++) begin w[i] = 8'($urandom); push_word(w[i]); end
        gb = got_data.size(); rb = rd_total; db = done_total;
        do_start(3, c0);
        wait_done(db, 50, ok);
        checks++; if (!ok) begin
            errors++; $display("FAIL partial_done_timeout got=0 exp=1");
        end
        checks++; if (busy !== 1'b0) begin
            errors++; $display("FAIL partial_busy got=%b exp=0", busy);
        end
        n = got_data.size() - gb;
        checks++; if (n != 3) begin
            errors++; $display("FAIL partial_count got=%0d exp=3", n);
        end
        if (n == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++; if (got_data[gb+i] !== w[i] || got_last[gb+i] !== (i == 2)) begin
                    errors++; $display("FAIL partial_word%0d got=%h exp=%h", i, got_data[gb+i], w[i]);
                end
            end
        end
        repeat (2) @(negedge clk);
        checks++; if (rd_total - rb != 3 || fq.size() != 5) begin
            errors++; $display("FAIL partial_reads reads=%0d left=%0d exp 3/5", rd_total - rb, fq.size());
        end
    endtask

    task automatic test_stall();
        logic [DW-1:0] w[12];
        int gb, rb, db, c0, n, vs, vo;
        bit ok;
        flush_fifo();
        for (int i = 0; i < 12; i++) begin w[i] = 8'($urandom); push_word(w[i]); end
        gb = got_data.size(); rb = rd_total; db = done_total;
        vs = viol_stable; vo = viol_outs;
        ready_mode = 1;
        do_start(10, c0);
        repeat (4) @(posedge clk);
        #1 ready_mode = 3;
        repeat (6) @(posedge clk);
        #1 ready_mode = 1;
        wait_done(db, 400, ok);
        ready_mode = 0;
        checks++; if (!ok) begin
            errors++; $display("FAIL stall_done_timeout got=0 exp=1");
        end
        n = got_data.size() - gb;
        checks++; if (n != 10) begin
            errors++; $display("FAIL stall_count got=%0d exp=10", n);
        end
        if (n == 10) begin
            for (int i = 0; i < 10; i++) begin
                checks++; if (got_data[gb+i] !== w[i] || got_last[gb+i] !== (i == 9)) begin
                    errors++; $display("FAIL stall_word%0d got=%h/%b exp=%h/%b", i, got_data[gb+i], got_last[gb+i], w[i], i == 9);
                end
            end
        end
        checks++; if (viol_stable != vs) begin
            errors++; $display("FAIL stall_data_stable violations=%0d exp=0", viol_stable - vs);
        end
        checks++; if (viol_outs != vo) begin
            errors++; $display("FAIL stall_outstanding violations=%0d exp=0", viol_outs - vo);
        end
        repeat (2) @(negedge clk);
        checks++; if (rd_total - rb != 10 || fq.size() != 2) begin
            errors++; $display("FAIL stall_reads reads=%0d left=%0d exp 10/2", rd_total - rb, fq.size());
        end
    endtask

    task automatic test_trickle();
        logic [DW-1:0] w[4];
        int gb, db, c0, n, ve;
        bit ok;
        flush_fifo();
        ready_mode = 0;
        gb = got_data.size(); db = done_total; ve = viol_empty;
        do_start(4, c0);
        @(negedge clk);
        checks++; if (busy !== 1'b1 || fifo_rd_en !== 1'b0) begin
            errors++; $display("FAIL trickle_wait busy=%b rd=%b exp 1/0", busy, fifo_rd_en);
        end
        for (int k = 0; k < 4; k++) begin
            w[k] = 8'($urandom);
            repeat (2) @(posedge clk);
            push_word(w[k]);
        end
        wait_done(db, 50, ok);
        checks++; if (!ok) begin
            errors++; $display("FAIL trickle_done_timeout got=0 exp=1");
        end
        checks++; if (viol_empty != ve) begin
            errors++; $display("FAIL trickle_rd_when_empty count=%0d exp=0", viol_empty - ve);
        end
        n = got_data.size() - gb;
        checks++; if (n != 4) begin
            errors++; $display("FAIL trickle_count got=%0d exp=4", n);
        end
        if (n == 4) begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (got_data[gb+i] !== w[i]) begin
                    errors++; $display("FAIL trickle_word%0d got=%h exp=%h", i, got_data[gb+i], w[i]);
                end
            end
        end
    endtask

    task automatic test_zero_and_ignore();
        int gb, rb, db, c0, n;
        bit ok;
        rb = rd_total; db = done_total;
        do_start(0, c0);
        @(negedge clk);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL zero_done done=%b busy=%b exp 1/0", done, busy);
        end
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || rd_total != rb) begin
            errors++; $display("FAIL zero_after done=%b busy=%b reads=%0d exp 0/0/0", done, busy, rd_total - rb);
        end
        flush_fifo();
        for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
        gb = got_data.size(); rb = rd_total; db = done_total;
        do_start(3, c0);
        @(posedge clk); #1;
        start = 1'b1; burst_len = LW'(5);
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(db, 50, ok);
        repeat (3) @(negedge clk);
        n = got_data.size() - gb;
        checks++; if (!ok || n != 3 || rd_total - rb != 3) begin
            errors++; $display("FAIL ignore_start ok=%0d words=%0d reads=%0d exp 1/3/3", ok, n, rd_total - rb);
        end
        checks++; if (done_total - db != 1 || fq.size() != 3) begin
            errors++; $display("FAIL ignore_done dones=%0d left=%0d exp 1/3", done_total - db, fq.size());
        end
        checks++; if (viol_busy != 0) begin
            errors++; $display("FAIL done_with_busy count=%0d exp=0", viol_busy);
        end
    endtask

    task automatic test_abort();
        logic [DW-1:0] w[6];
        int gb, db, c0, n;
        bit ok;
        flush_fifo();
        for (int i = 0; i < 6; i++) begin w[i] = 8'($urandom); push_word(w[i]); end
        ready_mode = 3;
        do_start(5, c0);
        repeat (6) @(negedge clk);
        checks++; if (m_valid !== 1'b1 || fq.size() != 4) begin
            errors++; $display("FAIL abort_prefill valid=%b left=%0d exp 1/4", m_valid, fq.size());
        end
        #2 rst = 1'b0;
        #1;
        checks++; if ({busy, done, m_valid, m_last, fifo_rd_en} !== 5'b0 || m_data !== 8'h00) begin
            errors++; $display("FAIL abort_outputs ctrl=%b data=%h exp 00000/00", {busy, done, m_valid, m_last, fifo_rd_en}, m_data);
        end
        @(negedge clk);
        rst = 1'b1;
        ready_mode = 0;
        gb = got_data.size(); db = done_total;
        do_start(2, c0);
        wait_done(db, 50, ok);
        n = got_data.size() - gb;
        checks++; if (!ok || n != 2) begin
            errors++; $display("FAIL abort_rerun ok=%0d words=%0d exp 1/2", ok, n);
        end
        if (n == 2) begin
            checks++; if (got_data[gb] !== w[2] || got_data[gb+1] !== w[3] || got_last[gb+1] !== 1'b1) begin
                errors++; $display("FAIL abort_words got=%h,%h exp=%h,%h", got_data[gb], got_data[gb+1], w[2], w[3]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_partial();
        test_stall();
        test_trickle();
        test_zero_and_ignore();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for the team's synchronous FIFO. On a start command it pulls a programmed number of words out of the FIFO through the FIFO's `rd_en`/`FIFO_empty`/`data_out` port, absorbing the FIFO's one-cycle registered read latency. It presents the words on a valid/ready stream with a last-word flag. A 2-entry output buffer sustains one word per cycle under continuous `m_ready` and never over-reads the FIFO when the consumer stalls.

## Interface
- `DATA_WIDTH`, 8, word width; must match the FIFO.
- `LEN_WIDTH`, 6, burst-length width; max burst 2^LEN_WIDTH-1 words.

- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  burst request, sampled only while `busy`=0.
- `burst_len`  in  LEN_WIDTH  words to read; sampled with `start`.
- `busy`  out  1  high from accepted `start` until last word handshaken.
- `done`  out  1  one-cycle pulse after final word handshake (or for zero-length burst).
- `fifo_empty`  in  1  FIFO `FIFO_empty`.
- `fifo_data`  in  DATA_WIDTH  FIFO `data_out`.
- `fifo_rd_en`  out  1  FIFO `rd_en`; combinational.
- `m_valid`  out  1  stream word valid.
- `m_ready`  in  1  consumer accepts word when `m_valid`&`m_ready`.
- `m_data`  out  DATA_WIDTH  stream word (buffer head).
- `m_last`  out  1  high with the final word of the burst.

## Operation
- States: IDLE, RUN. Reset → IDLE. All outputs reset to 0; buffer, counters and `inflight` reset to 0.
- IDLE: `start`=1 with `burst_len`≠0 → load `issue_rem`=`out_rem`=`burst_len`, `busy`=1, go to RUN. `start` with `burst_len`=0 → `done`=1 next cycle, stay IDLE, no reads. `start` while `busy`=1 is ignored.
- `pop` = `m_valid` & `m_ready`.
- `fifo_rd_en` = RUN & `issue_rem`≠0 & !`fifo_empty` & (`occ` + `inflight` < 2 + `pop`).
  - `occ` is buffer occupancy, 0..2.
  - `inflight` is a register equal to last cycle's `fifo_rd_en`.
- Each issued read decrements `issue_rem`. `fifo_rd_en` is never asserted while `fifo_empty`=1.
- When `inflight`=1, `fifo_data` is written into the buffer tail on the next edge. Simultaneous capture and `pop` keeps `occ` unchanged.
- Buffer invariants: order preserved; `occ`+`inflight` ≤ 2 at all times, so no word is ever dropped.
- `m_valid` = `occ`≠0. `m_data` = head entry, held stable while `m_valid` & !`m_ready`.
- `m_last` = `m_valid` & (`out_rem`=1). Each `pop` decrements `out_rem`.
- `pop` with `out_rem`=1 → next cycle: state IDLE, `busy`=0, `done`=1 for exactly one cycle.
- FIFO going empty mid-burst only pauses issue; the burst resumes when data arrives. There is no timeout.
- `rst` low mid-burst aborts immediately: all state cleared, buffered and in-flight words discarded. The FIFO read pointer is not rewound.
- Counter widths are LEN_WIDTH; counters never decrement below 0.

## Timing
- `start` sampled at edge E0.
- With the FIFO non-empty: `fifo_rd_en`=1 in the cycle after E0. FIFO updates at E1. Word captured at E2. `m_valid`=1 after E2, so first-word latency is 2 cycles from start acceptance.
- Steady state with `m_ready`=1 and FIFO non-empty: one read and one output word per cycle, no bubbles.
- `m_ready` low: at most 2 further reads are issued (buffer fills), then `fifo_rd_en` stays 0 until a `pop`.
- `done` and `busy` falling occur at the same edge, one edge after the final handshake. A new `start` is accepted in the cycle `done`=1.

## Test plan
- FIFO preloaded with 0x10..0x14, `burst_len`=5, `m_ready`=1 → `m_valid` 2 cycles after start; 0x10..0x14 on consecutive cycles; `m_last` only with 0x14; `done` pulse next cycle; exactly 5 `fifo_rd_en` cycles.
- FIFO holding 8 words, `burst_len`=3 → exactly 3 reads; FIFO left with 5 words; `busy` falls after the 3rd handshake.
- `m_ready` toggling 1/0 (and held low 6 cycles) with `burst_len`=10 → all 10 words in order, none dropped or duplicated; `m_data` stable while stalled; never more than 2 reads outstanding beyond pops.
- FIFO empty at start, words written one at a time every 4 cycles, `burst_len`=4 → `fifo_rd_en` never high while `fifo_empty`=1; 4 words delivered in order, then `done`.
- `burst_len`=0 start → `done`=1 next cycle, `busy` stays 0, no reads. `start` while `busy` → ignored, burst length unchanged.
- `rst` pulsed low mid-burst with `occ`=2 → all outputs 0 immediately; IDLE after release; new burst of 2 → next 2 FIFO words delivered correctly.
